// File: rtl/nkmm_boot_ctrl.sv
// nkmm_boot_ctrl: host-driven program loader and run/step/halt controller for nkmm_cpu
module nkmm_boot_ctrl #(
  parameter int INSN_WIDTH = 32,
  parameter int PMEM_AW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [PMEM_AW:0]      cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [INSN_WIDTH-1:0] wr_data_i,
  output logic                  pmem_we_o,
  output logic [PMEM_AW-1:0]    pmem_addr_o,
  output logic [INSN_WIDTH-1:0] pmem_data_o,
  output logic                  cpu_rst_o,
  output logic [1:0]            state_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           run_cycles_o
);
  typedef enum logic [1:0] {S_HALT = 2'b00, S_LOAD = 2'b01, S_RUN = 2'b10, S_STEP = 2'b11} state_t;
  localparam logic [1:0] OP_LOAD = 2'b00, OP_RUN = 2'b01, OP_HALT = 2'b10, OP_STEP = 2'b11;
  localparam logic [PMEM_AW:0] ONE = 1;
  localparam logic [PMEM_AW:0] DEPTH = {1'b1, {PMEM_AW{1'b0}}};
  state_t state, state_d;
  logic [PMEM_AW:0] cnt, len, rem, load_len;
  logic cmd_acc, wr_acc, done_d, err_d;
  assign state_o     = state;
  assign cmd_ready_o = (state == S_HALT) || (state == S_RUN);
  assign wr_ready_o  = (state == S_LOAD);
  assign cpu_rst_o   = !((state == S_RUN) || (state == S_STEP));
  assign cmd_acc     = cmd_valid_i && cmd_ready_o;
  assign wr_acc      = wr_valid_i && wr_ready_o;
  assign load_len    = cmd_len_i[PMEM_AW] ? DEPTH : cmd_len_i;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_HALT;
    else state <= state_d;
  // next state and completion/error pulses
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state)
      S_HALT:
        if (cmd_acc)
          case (cmd_op_i)
            OP_LOAD: if (load_len == '0) done_d = 1'b1; else state_d = S_LOAD;
            OP_RUN:  state_d = S_RUN;
            OP_STEP: if (cmd_len_i == '0) done_d = 1'b1; else state_d = S_STEP;
            default: state_d = S_HALT;
          endcase
      S_LOAD:
        if (wr_acc && (cnt + ONE == len)) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end
      S_RUN:
        if (cmd_acc) begin
          if (cmd_op_i == OP_HALT) state_d = S_HALT;
          else err_d = 1'b1;
        end
      S_STEP:
        if (rem == ONE) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end
    endcase
  end
  // datapath: word counter, pmem write port, step countdown, cycle counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt          <= '0;
      len          <= '0;
      rem          <= '0;
      pmem_we_o    <= 1'b0;
      pmem_addr_o  <= '0;
      pmem_data_o  <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      run_cycles_o <= '0;
    end else begin
      done_o    <= done_d;
      err_o     <= err_d;
      pmem_we_o <= wr_acc;
      if (wr_acc) begin
        pmem_addr_o <= cnt[PMEM_AW-1:0];
        pmem_data_o <= wr_data_i;
        cnt         <= cnt + ONE;
      end
      if (state == S_STEP) rem <= rem - ONE;
      if (!cpu_rst_o && run_cycles_o != '1) run_cycles_o <= run_cycles_o + 32'd1;
      if (state == S_HALT && cmd_acc) begin
        if (cmd_op_i == OP_LOAD) begin
          cnt <= '0;
          len <= load_len;
        end
        if (cmd_op_i == OP_RUN || cmd_op_i == OP_STEP) run_cycles_o <= '0;
        if (cmd_op_i == OP_STEP) rem <= cmd_len_i;
      end
    end
endmodule

// File: tb/tb_nkmm_boot_ctrl.sv
// tb_nkmm_boot_ctrl: directed scenario tests for nkmm_boot_ctrl
module tb_nkmm_boot_ctrl;
  localparam logic [1:0] OP_LOAD = 2'b00, OP_RUN = 2'b01, OP_HALT = 2'b10, OP_STEP = 2'b11;
  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, wr_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [10:0] cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic cmd_ready, wr_ready, pmem_we, cpu_rst, done, err;
  logic [9:0] pmem_addr;
  logic [31:0] pmem_data, run_cycles;
  logic [1:0] state;
  int vecs = 0, errs = 0;

  nkmm_boot_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .pmem_we_o(pmem_we), .pmem_addr_o(pmem_addr), .pmem_data_o(pmem_data),
    .cpu_rst_o(cpu_rst), .state_o(state), .done_o(done), .err_o(err), .run_cycles_o(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic issue_cmd(input logic [1:0] op, input logic [10:0] len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    vecs++;
    if ({cpu_rst, state, cmd_ready, wr_ready, pmem_we, pmem_addr, pmem_data, done, err, run_cycles} !== {1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 32'd0}) begin
      errs++;
      $display("FAIL reset_values: got rst=%b st=%b cr=%b wr=%b we=%b a=%0d d=%h dn=%b er=%b rc=%0d", cpu_rst, state, cmd_ready, wr_ready, pmem_we, pmem_addr, pmem_data, done, err, run_cycles);
    end
    @(negedge clk);
    rst = 1'b1;
    wr_valid = 1'b1;
    wr_data = 32'hDEAD;
    @(negedge clk);
    wr_valid = 1'b0;
    vecs++;
    if ({pmem_we, wr_ready, state} !== {1'b0, 1'b0, 2'b00}) begin
      errs++;
      $display("FAIL word_outside_load: got we=%b wr_ready=%b state=%b, want 0 0 00", pmem_we, wr_ready, state);
    end
  endtask

  task automatic test_load_b2b;
    issue_cmd(OP_LOAD, 11'd4);
    vecs++;
    if ({state, cmd_ready, wr_ready} !== {2'b01, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL load_enter: got state=%b cmd_ready=%b wr_ready=%b, want 01 0 1", state, cmd_ready, wr_ready);
    end
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1;
      wr_data = 32'hA0 + k;
      @(negedge clk);
      vecs++;
      if ({pmem_we, pmem_addr, pmem_data, done} !== {1'b1, 10'(k), 32'hA0 + 32'(k), k == 3}) begin
        errs++;
        $display("FAIL load_b2b_write%0d: got we=%b addr=%0d data=%h done=%b, want 1 %0d %h %b", k, pmem_we, pmem_addr, pmem_data, done, k, 32'hA0 + k, k == 3);
      end
    end
    wr_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if ({state, done, pmem_we, wr_ready} !== {2'b00, 1'b0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL load_b2b_after: got state=%b done=%b we=%b wr_ready=%b, want 00 0 0 0", state, done, pmem_we, wr_ready);
    end
  endtask

  task automatic test_load_gap;
    logic [31:0] exp_d [3] = '{32'hB0, 32'hB1, 32'hB2};
    issue_cmd(OP_LOAD, 11'd3);
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data = exp_d[k];
      @(negedge clk);
      wr_valid = 1'b0;
      vecs++;
      if ({pmem_we, pmem_addr, pmem_data, done} !== {1'b1, 10'(k), exp_d[k], k == 2}) begin
        errs++;
        $display("FAIL load_gap_write%0d: got we=%b addr=%0d data=%h done=%b, want 1 %0d %h %b", k, pmem_we, pmem_addr, pmem_data, done, k, exp_d[k], k == 2);
      end
      if (k == 0)
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          vecs++;
          if ({pmem_we, done, state} !== {1'b0, 1'b0, 2'b01}) begin
            errs++;
            $display("FAIL load_gap_idle%0d: got we=%b done=%b state=%b, want 0 0 01", g, pmem_we, done, state);
          end
        end
    end
    @(negedge clk);
  endtask

  task automatic test_load_max;
    int writes = 0, done_at = -1;
    issue_cmd(OP_LOAD, 11'h7FF);
    for (int k = 0; k < 1100 && state == 2'b01; k++) begin
      wr_valid = 1'b1;
      wr_data = 32'(k);
      @(negedge clk);
      if (pmem_we) writes++;
      if (done) done_at = int'(pmem_addr);
    end
    wr_valid = 1'b0;
    vecs++;
    if (writes != 1024 || done_at != 1023 || state !== 2'b00) begin
      errs++;
      $display("FAIL load_clamp: got writes=%0d done_addr=%0d state=%b, want 1024 1023 00", writes, done_at, state);
    end
    @(negedge clk);
  endtask

  task automatic test_step;
    issue_cmd(OP_STEP, 11'd5);
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if ({cpu_rst, state, done, cmd_ready} !== {1'b0, 2'b11, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL step_cycle%0d: got cpu_rst=%b state=%b done=%b cmd_ready=%b, want 0 11 0 0", i, cpu_rst, state, done, cmd_ready);
      end
      @(negedge clk);
    end
    vecs++;
    if ({cpu_rst, state, done, run_cycles} !== {1'b1, 2'b00, 1'b1, 32'd5}) begin
      errs++;
      $display("FAIL step_end: got cpu_rst=%b state=%b done=%b rc=%0d, want 1 00 1 5", cpu_rst, state, done, run_cycles);
    end
    @(negedge clk);
    vecs++;
    if ({done, run_cycles} !== {1'b0, 32'd5}) begin
      errs++;
      $display("FAIL step_hold: got done=%b rc=%0d, want 0 5", done, run_cycles);
    end
  endtask

  task automatic test_run_halt;
    issue_cmd(OP_RUN, 11'd0);
    vecs++;
    if ({cpu_rst, state, run_cycles} !== {1'b0, 2'b10, 32'd0}) begin
      errs++;
      $display("FAIL run_enter: got cpu_rst=%b state=%b rc=%0d, want 0 10 0", cpu_rst, state, run_cycles);
    end
    cmd_valid = 1'b1;
    cmd_op = OP_LOAD;
    cmd_len = 11'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    vecs++;
    if ({err, state, wr_ready} !== {1'b1, 2'b10, 1'b0}) begin
      errs++;
      $display("FAIL run_reject_load: got err=%b state=%b wr_ready=%b, want 1 10 0", err, state, wr_ready);
    end
    @(negedge clk);
    vecs++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL run_err_pulse: got err=%b, want 0", err);
    end
    repeat (7) @(negedge clk);
    vecs++;
    if ({cpu_rst, run_cycles} !== {1'b0, 32'd9}) begin
      errs++;
      $display("FAIL run_count: got cpu_rst=%b rc=%0d, want 0 9", cpu_rst, run_cycles);
    end
    cmd_valid = 1'b1;
    cmd_op = OP_HALT;
    @(negedge clk);
    cmd_valid = 1'b0;
    vecs++;
    if ({cpu_rst, state, run_cycles} !== {1'b1, 2'b00, 32'd10}) begin
      errs++;
      $display("FAIL run_halt: got cpu_rst=%b state=%b rc=%0d, want 1 00 10", cpu_rst, state, run_cycles);
    end
    @(negedge clk);
    vecs++;
    if (run_cycles !== 32'd10) begin
      errs++;
      $display("FAIL run_hold: got rc=%0d, want 10", run_cycles);
    end
  endtask

  task automatic test_zero_len;
    logic [1:0] ops [2] = '{OP_LOAD, OP_STEP};
    for (int i = 0; i < 2; i++) begin
      issue_cmd(ops[i], 11'd0);
      vecs++;
      if ({done, pmem_we, cpu_rst, state} !== {1'b1, 1'b0, 1'b1, 2'b00}) begin
        errs++;
        $display("FAIL zero_len_op%0d: got done=%b we=%b cpu_rst=%b state=%b, want 1 0 1 00", ops[i], done, pmem_we, cpu_rst, state);
      end
      @(negedge clk);
      vecs++;
      if ({done, cpu_rst} !== {1'b0, 1'b1}) begin
        errs++;
        $display("FAIL zero_len_after%0d: got done=%b cpu_rst=%b, want 0 1", ops[i], done, cpu_rst);
      end
    end
  endtask

  task automatic test_async_reset;
    issue_cmd(OP_LOAD, 11'd8);
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data = 32'hC0 + k;
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({state, cpu_rst, wr_ready, pmem_we, pmem_addr, run_cycles} !== {2'b00, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0}) begin
      errs++;
      $display("FAIL async_reset: got state=%b cpu_rst=%b wr_ready=%b we=%b addr=%0d rc=%0d, want 00 1 0 0 0 0", state, cpu_rst, wr_ready, pmem_we, pmem_addr, run_cycles);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    rst = 1'b1;
    vecs++;
    if ({done, pmem_we} !== {1'b0, 1'b0}) begin
      errs++;
      $display("FAIL async_no_done: got done=%b we=%b, want 0 0", done, pmem_we);
    end
    issue_cmd(OP_LOAD, 11'd2);
    wr_valid = 1'b1;
    wr_data = 32'hD0;
    @(negedge clk);
    wr_valid = 1'b0;
    vecs++;
    if ({pmem_we, pmem_addr, pmem_data} !== {1'b1, 10'd0, 32'hD0}) begin
      errs++;
      $display("FAIL reload_addr0: got we=%b addr=%0d data=%h, want 1 0 d0", pmem_we, pmem_addr, pmem_data);
    end
  endtask

  initial begin
    test_reset;
    test_load_b2b;
    test_load_gap;
    test_load_max;
    test_step;
    test_run_halt;
    test_zero_len;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/nkmm_boot_ctrl.md
# nkmm_boot_ctrl

Run controller for the nkmm CPU. It owns the program-memory write port and the CPU's synchronous reset. A host command port drives it:
- LOAD streams instruction words into program memory from address 0.
- RUN releases the CPU from reset.
- STEP releases the CPU for exactly N cycles.
- HALT returns the CPU to reset.

It sits between the host/debug interface and the `nkmm_cpu` + program-memory pair.

## Interface
Parameters:
- INSN_WIDTH, 32, instruction word width (matches CPU program bus)
- PMEM_AW, 10, program memory address width; depth = 2^PMEM_AW

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_op_i  in  2  00 LOAD, 01 RUN, 10 HALT, 11 STEP
- cmd_len_i  in  PMEM_AW+1  LOAD word count / STEP cycle count
- wr_valid_i  in  1  instruction word valid (LOAD only)
- wr_ready_o  out  1  word accepted when valid & ready
- wr_data_i  in  INSN_WIDTH  instruction word
- pmem_we_o  out  1  program memory write strobe
- pmem_addr_o  out  PMEM_AW  write address
- pmem_data_o  out  INSN_WIDTH  write data
- cpu_rst_o  out  1  active-high synchronous reset to `nkmm_cpu`
- state_o  out  2  00 HALT, 01 LOAD, 10 RUN, 11 STEP
- done_o  out  1  one-cycle pulse: LOAD or STEP completed
- err_o  out  1  one-cycle pulse: illegal command rejected
- run_cycles_o  out  32  cycles the CPU was out of reset since the last RUN/STEP start

## Operation
- States: HALT, LOAD, RUN, STEP. `rst` low forces HALT immediately, regardless of the current state.
- Reset values:
  - cpu_rst_o=1
  - state_o=00
  - cmd_ready_o=1
  - wr_ready_o=0
  - pmem_we_o=0, pmem_addr_o=0, pmem_data_o=0
  - done_o=0, err_o=0
  - run_cycles_o=0
- cmd_ready_o=1 in HALT and RUN; 0 in LOAD and STEP.
- HALT state:
  - cpu_rst_o=1.
  - LOAD: effective length is L = min(cmd_len_i, 2^PMEM_AW). Clears the word counter. Goes to LOAD, or, if L=0, stays in HALT and pulses done_o.
  - RUN: clears run_cycles_o and goes to RUN.
  - STEP: N=cmd_len_i. Clears run_cycles_o. Goes to STEP, or, if N=0, stays in HALT and pulses done_o.
  - HALT: no-op, no pulse.
- LOAD state:
  - wr_ready_o=1.
  - Each accepted word k (k=0..L-1) produces a write one cycle later: pmem_we_o=1, pmem_addr_o=k, pmem_data_o=word.
  - After word L-1 is accepted, wr_ready_o drops and the state returns to HALT. done_o pulses in the same cycle as the final write.
  - Words presented outside LOAD are never accepted.
- RUN state:
  - cpu_rst_o=0.
  - HALT: goes to HALT.
  - LOAD, RUN, STEP: rejected. err_o pulses, state unchanged.
- STEP state:
  - cpu_rst_o=0 for exactly N cycles, then HALT with done_o pulsing on the first HALT cycle.
  - Commands are not accepted.
- run_cycles_o increments on every cycle with cpu_rst_o=0 and saturates at 2^32-1. It holds its value in HALT and LOAD.
- The CPU restarts from pc 0 on every RUN/STEP, because HALT resets it.

## Timing
- All outputs are registered. A command accepted at edge t takes effect (state_o, cpu_rst_o) from cycle t+1.
- RUN accepted at t: cpu_rst_o=0 from t+1. HALT accepted in RUN at t: cpu_rst_o=1 from t+1.
- Word-accept to pmem write latency: 1 cycle. A back-to-back valid stream writes one word per cycle.
- wr_valid_i may deassert mid-LOAD. The counter holds and no write is issued.
- STEP N: cpu_rst_o low for exactly N consecutive cycles; run_cycles_o=N afterwards.
- Async reset mid-LOAD or mid-STEP: the transfer is aborted, no done_o pulse, and the outputs take their reset values.

## Test plan
- Reset, then LOAD len=4 with words 0xA0..0xA3 back-to-back -> pmem writes at addr 0..3 on 4 consecutive cycles; done_o coincides with the addr-3 write; state_o=00 next cycle.
- LOAD len=3 with a 2-cycle wr_valid_i gap after word 0 -> exactly 3 writes at addr 0,1,2 with data in order; no write during the gap.
- STEP len=5 -> cpu_rst_o low for exactly 5 cycles; done_o on the next cycle; run_cycles_o=5.
- RUN, wait 10 cycles, then HALT -> cpu_rst_o low 10 cycles from t+1 of RUN accept; run_cycles_o=10; a LOAD issued during RUN pulses err_o and the state stays RUN.
- LOAD len=0 and STEP len=0 from HALT -> done_o pulse, no pmem write, cpu_rst_o stays 1.
- Assert rst low in the middle of a LOAD len=8 after 3 words -> immediate HALT; cpu_rst_o=1; no done_o; a new LOAD after release writes from addr 0.
